// File: rtl/debounce_botoes.sv
// debounce_botoes: per-channel push-button debouncer. Each raw active-low key
// is synchronised, qualified over a stability window, and turned into a clean
// level plus registered one-clock press / release / long-press pulses.
// Channels share nothing but the clock and reset.
// estado_dbg_o exposes every channel FSM state (2 bits per channel) for
// checkers. Encoding: 0 SOLTO, 1 CONF_PRESS, 2 PRESSIONADO, 3 CONF_SOLTA.
module debounce_botoes #(
  parameter int N_BOTOES        = 3,
  parameter int DEBOUNCE_CICLOS = 1000000,
  parameter int LONG_CICLOS     = 50000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_BOTOES-1:0]   key_n,
  output logic [N_BOTOES-1:0]   pressionado,
  output logic [N_BOTOES-1:0]   pulso_press,
  output logic [N_BOTOES-1:0]   pulso_solta,
  output logic [N_BOTOES-1:0]   pulso_longo,
  output logic [2*N_BOTOES-1:0] estado_dbg_o
);

  localparam int DW = $clog2(DEBOUNCE_CICLOS);
  localparam int LW = $clog2(LONG_CICLOS + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CICLOS - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CICLOS - 1);
  localparam logic [LW-1:0] LONG_SAT = LW'(LONG_CICLOS);

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_PRESS  = 2'd1,
    PRESSIONADO = 2'd2,
    CONF_SOLTA  = 2'd3
  } estado_t;

  for (genvar g = 0; g < N_BOTOES; g++) begin : g_canal
    logic          sync1_q, sync2_q;
    estado_t       estado_q, estado_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [LW-1:0] long_q, long_d;
    logic          done_q, done_d;
    logic          nivel_q, nivel_d;
    logic          press_q, press_d;
    logic          solta_q, solta_d;
    logic          longo_q, longo_d;

    // Two-flop synchroniser; idles at 1 (released) out of reset.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= key_n[g];
        sync2_q <= sync1_q;
      end
    end

    // Next-state, counters and pulse requests from the synchronised sample.
    always_comb begin
      estado_d = estado_q;
      deb_d    = deb_q;
      long_d   = long_q;
      done_d   = done_q;
      press_d  = 1'b0;
      solta_d  = 1'b0;
      longo_d  = 1'b0;
      case (estado_q)
        SOLTO: begin
          if (!sync2_q) begin
            estado_d = CONF_PRESS;
            deb_d    = '0;
          end
        end
        CONF_PRESS: begin
          if (sync2_q) begin
            estado_d = SOLTO;
          end else if (deb_q == DEB_MAX) begin
            estado_d = PRESSIONADO;
            long_d   = '0;
            done_d   = 1'b0;
            press_d  = 1'b1;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        PRESSIONADO: begin
          // Long counter saturates so a very long hold never re-arms it.
          if (long_q != LONG_SAT) long_d = long_q + 1'b1;
          if (long_q == LONG_MAX && !done_q) begin
            longo_d = 1'b1;
            done_d  = 1'b1;
          end
          if (sync2_q) begin
            estado_d = CONF_SOLTA;
            deb_d    = '0;
          end
        end
        CONF_SOLTA: begin
          // A bounce back low resumes the press; long state is kept.
          if (!sync2_q) begin
            estado_d = PRESSIONADO;
          end else if (deb_q == DEB_MAX) begin
            estado_d = SOLTO;
            solta_d  = 1'b1;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        default: estado_d = SOLTO;
      endcase
      nivel_d = (estado_d == PRESSIONADO) || (estado_d == CONF_SOLTA);
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        estado_q <= SOLTO;
        deb_q    <= '0;
        long_q   <= '0;
        done_q   <= 1'b0;
        nivel_q  <= 1'b0;
        press_q  <= 1'b0;
        solta_q  <= 1'b0;
        longo_q  <= 1'b0;
      end else begin
        estado_q <= estado_d;
        deb_q    <= deb_d;
        long_q   <= long_d;
        done_q   <= done_d;
        nivel_q  <= nivel_d;
        press_q  <= press_d;
        solta_q  <= solta_d;
        longo_q  <= longo_d;
      end
    end

    assign pressionado[g]        = nivel_q;
    assign pulso_press[g]        = press_q;
    assign pulso_solta[g]        = solta_q;
    assign pulso_longo[g]        = longo_q;
    assign estado_dbg_o[2*g +: 2] = estado_q;
  end

endmodule

// File: doc/debounce_botoes.md
DEBOUNCE_BOTOES -- requirements
Module: debounce_botoes

Interface
REQ-001 SHALL have parameter N_BOTOES, default 3, number of independent push-button channels (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CICLOS, default 1000000 (20 ms at 50 MHz), stability window in clocks; legal range >= 2.
REQ-003 SHALL have parameter LONG_CICLOS, default 50000000 (1 s at 50 MHz), long-press threshold in clocks; legal only if > DEBOUNCE_CICLOS.
REQ-004 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port key_n, input, N_BOTOES, raw asynchronous buttons, 0 = pressed.
REQ-007 SHALL have port pressionado, output, N_BOTOES, debounced level, 1 = pressed.
REQ-008 SHALL have port pulso_press, output, N_BOTOES, one-clock pulse on confirmed press.
REQ-009 SHALL have port pulso_solta, output, N_BOTOES, one-clock pulse on confirmed release.
REQ-010 SHALL have port pulso_longo, output, N_BOTOES, one-clock pulse when a press lasts LONG_CICLOS.

Function
REQ-011 Each channel SHALL pass key_n through a 2-flop synchronizer; the FSM SHALL use only the synchronized sample s (s = 0 means pressed).
REQ-012 Each channel SHALL own an FSM with states SOLTO, CONF_PRESS, PRESSIONADO and CONF_SOLTA, plus a debounce counter and a long-press counter; there SHALL be no sharing between channels.
REQ-013 In SOLTO with s = 0, the FSM SHALL go to CONF_PRESS and clear the debounce counter.
REQ-014 In CONF_PRESS with s = 1, the FSM SHALL return to SOLTO with no pulse.
REQ-015 In CONF_PRESS with s = 0, the counter SHALL increment; when the counter is DEBOUNCE_CICLOS-1, the FSM SHALL instead go to PRESSIONADO, clear the long counter and the long-done flag, and assert pulso_press for exactly one cycle.
REQ-016 Press latency SHALL be as follows: pulso_press is high in the cycle after clock edge DEBOUNCE_CICLOS+2, where edge 0 is the first edge that samples key_n low, given stable input.
REQ-017 In PRESSIONADO with s = 1, the FSM SHALL go to CONF_SOLTA and clear the debounce counter.
REQ-018 CONF_SOLTA SHALL mirror CONF_PRESS:
- s = 0 returns to PRESSIONADO with no pulse and keeps the long counter and long-done flag.
- s = 1 for DEBOUNCE_CICLOS edges goes to SOLTO and asserts pulso_solta for one cycle.
REQ-019 pressionado SHALL be 1 exactly while the state is PRESSIONADO or CONF_SOLTA; it SHALL be registered with no glitches.
REQ-020 The long counter SHALL increment each cycle in PRESSIONADO and SHALL hold in CONF_SOLTA.
REQ-021 When the long counter reaches LONG_CICLOS-1 and the long-done flag is 0, the block SHALL assert pulso_longo for one cycle and set the flag; there SHALL be at most one pulso_longo per press and no auto-repeat.
REQ-022 The long counter SHALL saturate and never wrap. Counter widths SHALL be clog2(LONG_CICLOS+1) bits and clog2(DEBOUNCE_CICLOS) bits.
REQ-023 pulso_press, pulso_solta and pulso_longo SHALL be registered; within one channel they SHALL be mutually exclusive in any cycle.
REQ-024 Simultaneous events on different channels SHALL be fully independent; multiple bits may pulse in the same cycle.

Reset
REQ-025 While reset_n = 0 at a rising edge:
- every FSM goes to SOLTO;
- synchronizer flops load 1;
- counters and long-done flags load 0;
- all outputs load 0.
REQ-026 Reset asserted mid-press SHALL abort the press with no pulso_solta.
REQ-027 If key_n is still low after reset_n returns to 1, the channel SHALL requalify through CONF_PRESS and emit a new pulso_press.
REQ-028 Reset SHALL override all other activity in the same cycle.

Verification (use DEBOUNCE_CICLOS=4, LONG_CICLOS=20, N_BOTOES=3)
REQ-029 Scenario: hold key_n[0] low from edge 0 -> pulso_press[0] is high only in the cycle after edge 6, and pressionado[0] = 1 from that cycle.
REQ-030 Scenario: key_n[1] glitches low for 3 cycles, then high -> no pulse and pressionado[1] stays 0.
REQ-031 Scenario: release after a confirmed press, with a 2-cycle bounce low at the start of the release -> one pulso_solta[0] only after 4 stable-high edges, and no extra pulso_press.
REQ-032 Scenario: hold key_n[2] low for 60 cycles -> exactly one pulso_longo[2], 20 cycles after pulso_press[2], and no repeat.
REQ-033 Scenario: press key_n[0] and key_n[1] on the same edge -> pulso_press = 3'b011 in a single cycle.
REQ-034 Scenario: reset_n = 0 for 1 cycle while key_n[0] is held and pressed -> all outputs 0 the next cycle, then a new pulso_press[0] 7 edges after reset release, and no pulso_solta.
